// File: rtl/index_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : index_stream_reader
// Purpose  : Consumer end of the ping-pong column-index double buffer. Drains
//            one filled bank (A, then B, then A, ...) through port 1 of that
//            bank's RAM. The indices leave as a valid/ready stream. A
//            credit-limited skid FIFO absorbs the RAM read latency. Each
//            drained bank is handed back to the writer with a one-cycle
//            release pulse.
// Ports    : clk, rst           - clock, synchronous active-high reset
//            bank_full[1:0]     - writer: bank filled ([0]=A, [1]=B)
//            bank_count_a/b     - valid entries per bank, sampled at bank start
//            bank_release[1:0]  - one-cycle pulse, bank returned to writer
//            rd_en_a/b, rd_addr - port-1 read enables and shared address
//            rd_data_a/b        - port-1 read data, RD_LAT cycles after enable
//            idx_out/valid/ready/last/bank - index stream to aggregation path
// Revision : 1.0 - initial release
// ============================================================================
module index_stream_reader #(
    parameter int K          = 1024,
    parameter int ADDR_W     = $clog2(K*K/32),
    parameter int IDX_W      = $clog2(K),
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        bank_full,
    input  logic [ADDR_W:0]   bank_count_a,
    input  logic [ADDR_W:0]   bank_count_b,
    output logic [1:0]        bank_release,
    output logic              rd_en_a,
    output logic              rd_en_b,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [IDX_W-1:0]  rd_data_a,
    input  logic [IDX_W-1:0]  rd_data_b,
    output logic [IDX_W-1:0]  idx_out,
    output logic              idx_valid,
    input  logic              idx_ready,
    output logic              idx_last,
    output logic              idx_bank
);

    localparam int c_PTR_W  = $clog2(FIFO_DEPTH);
    localparam int c_OCC_W  = $clog2(FIFO_DEPTH + 1);
    localparam int c_CRED_W = $clog2(FIFO_DEPTH + RD_LAT + 1);
    localparam int c_ENT_W  = IDX_W + 2;
    localparam logic [c_CRED_W-1:0] c_CREDIT_LIMIT = c_CRED_W'(FIFO_DEPTH);
    localparam logic [ADDR_W:0]     c_CNT_ONE      = (ADDR_W+1)'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_DRAIN   = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_nextState;
    logic                r_curBank;
    logic [ADDR_W:0]     r_count;
    logic [ADDR_W:0]     r_addr;
    logic [1:0]          r_release;

    // Read-return tracking: one slot per cycle of RAM latency.
    logic [RD_LAT-1:0]   r_pipeValid;
    logic [RD_LAT-1:0]   r_pipeLast;
    logic [RD_LAT-1:0]   r_pipeBank;

    // Skid FIFO entries are {last, bank, data}.
    logic [c_ENT_W-1:0]  r_fifoMem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]  r_wrPtr;
    logic [c_PTR_W-1:0]  r_rdPtr;
    logic [c_OCC_W-1:0]  r_occ;

    logic [c_CRED_W-1:0] w_inflight;
    logic                w_creditOk;
    logic                w_issue;
    logic                w_lastAddr;
    logic [ADDR_W:0]     w_startCount;
    logic                w_push;
    logic                w_pop;
    logic [c_ENT_W-1:0]  w_pushEntry;
    logic [c_ENT_W-1:0]  w_headEntry;

    assign w_startCount = r_curBank ? bank_count_b : bank_count_a;
    assign w_lastAddr   = (r_addr == (r_count - c_CNT_ONE));

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            w_inflight = w_inflight + c_CRED_W'(r_pipeValid[i]);
        end
    end

    // A read may be issued only if it is guaranteed a FIFO slot when it
    // returns. Every outstanding read and every queued entry holds a credit.
    // Because of this, a push can never hit a full FIFO.
    assign w_creditOk = (w_inflight + c_CRED_W'(r_occ)) < c_CREDIT_LIMIT;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_comb begin
        w_nextState = r_state;
        w_issue     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bank_full[r_curBank]) begin
                    w_nextState = (w_startCount == '0) ? S_RELEASE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_issue = w_creditOk;
                if (w_creditOk && w_lastAddr) begin
                    w_nextState = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Nothing is in flight, so no more pushes can arrive. The bank
                // is finished once its final queued entry leaves the FIFO.
                if ((w_inflight == '0) &&
                    ((r_occ == '0) || ((r_occ == c_OCC_W'(1)) && w_pop))) begin
                    w_nextState = S_RELEASE;
                end
            end
            S_RELEASE: begin
                w_nextState = S_IDLE;
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_curBank <= 1'b0;
            r_count   <= '0;
            r_addr    <= '0;
            r_release <= '0;
        end else begin
            r_state   <= w_nextState;
            r_release <= '0;
            case (r_state)
                S_IDLE: begin
                    if (bank_full[r_curBank]) begin
                        r_count <= w_startCount;
                        r_addr  <= '0;
                    end
                end
                S_ISSUE: begin
                    if (w_issue) begin
                        r_addr <= r_addr + c_CNT_ONE;
                    end
                end
                S_RELEASE: begin
                    r_release <= r_curBank ? 2'b10 : 2'b01;
                    r_curBank <= ~r_curBank;
                end
                default: begin
                end
            endcase
        end
    end

    assign rd_en_a      = w_issue & ~r_curBank;
    assign rd_en_b      = w_issue &  r_curBank;
    assign rd_addr      = w_issue ? r_addr[ADDR_W-1:0] : '0;
    assign bank_release = r_release;

    // ------------------------------------------------------------------
    // Read-return pipeline: a read leaves the last slot on the same cycle
    // that its data is on rd_data_*.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pipeValid <= '0;
        end else begin
            r_pipeValid[0] <= w_issue;
            for (int i = 1; i < RD_LAT; i++) begin
                r_pipeValid[i] <= r_pipeValid[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        r_pipeLast[0] <= w_lastAddr;
        r_pipeBank[0] <= r_curBank;
        for (int i = 1; i < RD_LAT; i++) begin
            r_pipeLast[i] <= r_pipeLast[i-1];
            r_pipeBank[i] <= r_pipeBank[i-1];
        end
    end

    assign w_push      = r_pipeValid[RD_LAT-1];
    assign w_pushEntry = {r_pipeLast[RD_LAT-1], r_pipeBank[RD_LAT-1],
                          r_pipeBank[RD_LAT-1] ? rd_data_b : rd_data_a};

    // ------------------------------------------------------------------
    // Skid FIFO. The pointers wrap naturally because the depth is a power of 2.
    // ------------------------------------------------------------------
    assign w_pop = idx_valid & idx_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_occ   <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + c_OCC_W'(1);
                2'b01:   r_occ <= r_occ - c_OCC_W'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifoMem[r_wrPtr] <= w_pushEntry;
        end
    end

    // The storage is not reset, so the outputs are forced to zero while the
    // FIFO is empty.
    assign w_headEntry = r_fifoMem[r_rdPtr];
    assign idx_valid   = (r_occ != '0);
    assign idx_out     = idx_valid ? w_headEntry[IDX_W-1:0] : '0;
    assign idx_last    = idx_valid & w_headEntry[IDX_W+1];
    assign idx_bank    = idx_valid & w_headEntry[IDX_W];

endmodule
`default_nettype wire
